// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared defaults and grant encoding for the writeback arbiter
package rf_wb_arbiter_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_RF_ZERO = 0;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_hold_slot.sv
// rtl/rf_wb_arbiter_wb_hold_slot.sv - 1-entry writeback holding register with zero-address drop
module wb_hold_slot
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned ZERO_ADDR = DEF_RF_ZERO
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              drain,
  output logic              load,
  output logic              hv,
  output logic [ADDR_W-1:0] ha,
  output logic [DATA_W-1:0] hd
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  // A full slot still accepts on the cycle it drains, so back-to-back streams never bubble.
  assign in_ready = ~hv | drain;
  assign load     = in_valid & in_ready & (in_addr != ZERO);

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      hv <= 1'b0;
      ha <= '0;
      hd <= '0;
    end else if (load) begin
      hv <= 1'b1;
      ha <= in_addr;
      hd <= in_data;
    end else if (drain) begin
      hv <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source register-file writeback arbiter with pending-write scoreboard
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned ZERO_ADDR = DEF_RF_ZERO
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic              r1_busy,
  output logic              r2_busy
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic              hv_a, hv_b, load_a, load_b, drain_a, drain_b;
  logic [ADDR_W-1:0] ha_a, ha_b;
  logic [DATA_W-1:0] hd_a, hd_b;
  logic              b_first;
  grant_e            grant;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_ADDR(ZERO_ADDR)) u_slot_a (
    .clock(clock), .n_rst(n_rst),
    .in_valid(a_valid), .in_addr(a_addr), .in_data(a_data), .in_ready(a_ready),
    .drain(drain_a), .load(load_a), .hv(hv_a), .ha(ha_a), .hd(hd_a)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_ADDR(ZERO_ADDR)) u_slot_b (
    .clock(clock), .n_rst(n_rst),
    .in_valid(b_valid), .in_addr(b_addr), .in_data(b_data), .in_ready(b_ready),
    .drain(drain_b), .load(load_b), .hv(hv_b), .ha(ha_b), .hd(hd_b)
  );

  always_comb begin
    grant     = (hv_b && (!hv_a || b_first)) ? GRANT_B : GRANT_A;
    drain_a   = hv_a && (grant == GRANT_A);
    drain_b   = hv_b && (grant == GRANT_B);
    rf_we     = hv_a | hv_b;
    rf_w_addr = '0;
    rf_w_data = '0;
    if (rf_we) begin
      rf_w_addr = (grant == GRANT_B) ? ha_b : ha_a;
      rf_w_data = (grant == GRANT_B) ? hd_b : hd_a;
    end
  end

  // Simultaneous loads put B ahead: the MEM-stage instruction issued earlier than the EX one.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      b_first <= 1'b0;
    end else if (load_a && load_b) begin
      b_first <= 1'b1;
    end else if (load_b && hv_a && !drain_a) begin
      b_first <= 1'b0;
    end else if (load_a && hv_b && !drain_b) begin
      b_first <= 1'b1;
    end
  end

  assign r1_busy = (r1_addr != ZERO) &&
                   ((hv_a && (ha_a == r1_addr)) || (hv_b && (ha_b == r1_addr)));
  assign r2_busy = (r2_addr != ZERO) &&
                   ((hv_a && (ha_a == r2_addr)) || (hv_b && (ha_b == r2_addr)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          n_rst = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, r1_addr = '0, r2_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, rf_we, r1_busy, r2_busy;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_ADDR(0)) dut (
    .clock(clock), .n_rst(n_rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_busy(r1_busy), .r2_busy(r2_busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending writes kept in program order; the write port always serves the oldest.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          src_b;
  } pend_t;
  pend_t q[$];

  function automatic logic m_ready(input logic src_b);
    logic held = 1'b0;
    foreach (q[i]) if (q[i].src_b == src_b) held = 1'b1;
    return !held || (q.size() > 0 && q[0].src_b == src_b);
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] r);
    logic hit = 1'b0;
    foreach (q[i]) if (q[i].addr == r) hit = 1'b1;
    return (r != 0) && hit;
  endfunction

  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      q.delete();
    end else begin
      logic ra, rb;
      ra = m_ready(1'b0);
      rb = m_ready(1'b1);
      if (q.size() > 0) void'(q.pop_front());
      if (b_valid && rb && b_addr != 0) q.push_back('{b_addr, b_data, 1'b1});
      if (a_valid && ra && a_addr != 0) q.push_back('{a_addr, a_data, 1'b0});
    end
  end

  int            write_count = 0;
  logic [DW-1:0] wlog[$];

  always @(negedge clock) begin
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    e_we   = q.size() > 0;
    e_addr = e_we ? q[0].addr : '0;
    e_data = e_we ? q[0].data : '0;
    check("rf_we", rf_we, e_we);
    check("rf_w_addr", rf_w_addr, e_addr);
    check("rf_w_data", rf_w_data, e_data);
    check("a_ready", a_ready, m_ready(1'b0));
    check("b_ready", b_ready, m_ready(1'b1));
    check("r1_busy", r1_busy, m_busy(r1_addr));
    check("r2_busy", r2_busy, m_busy(r2_addr));
    if (rf_we) begin
      write_count++;
      wlog.push_back(rf_w_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  logic [DW-1:0] exp_stream[8] = '{16'hB001, 16'hA001, 16'hB002, 16'hA002,
                                   16'hB003, 16'hA003, 16'hB004, 16'hA004};

  initial begin
    int ia, ib, run_a, run_b, wc;
    logic hs_a, hs_b;

    // Reset then idle
    tick();
    check("rst_rf_we", rf_we, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_busy", {r1_busy, r2_busy}, 0);
    n_rst = 1'b1;
    tick();
    check("idle_rf_we", rf_we, 0);

    // Single write
    a_valid = 1; a_addr = 5; a_data = 16'h1234; r1_addr = 5;
    tick();
    a_valid = 0;
    check("single_we", rf_we, 1);
    check("single_addr", rf_w_addr, 5);
    check("single_data", rf_w_data, 16'h1234);
    check("single_busy", r1_busy, 1);
    tick();
    check("single_we_clr", rf_we, 0);
    check("single_busy_clr", r1_busy, 0);

    // Zero-register destination
    b_valid = 1; b_addr = 0; b_data = 16'hDEAD; r1_addr = 0;
    check("zero_b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    check("zero_we", rf_we, 0);
    check("zero_busy", r1_busy, 0);
    tick();
    check("zero_we2", rf_we, 0);

    // Same-cycle conflict on one destination
    a_valid = 1; a_addr = 3; a_data = 16'hAAAA;
    b_valid = 1; b_addr = 3; b_data = 16'hBBBB; r1_addr = 3;
    tick();
    a_valid = 0; b_valid = 0;
    check("conf1_addr", rf_w_addr, 3);
    check("conf1_data", rf_w_data, 16'hBBBB);
    check("conf1_busy", r1_busy, 1);
    tick();
    check("conf2_addr", rf_w_addr, 3);
    check("conf2_data", rf_w_data, 16'hAAAA);
    check("conf2_busy", r1_busy, 1);
    tick();
    check("conf_done_we", rf_we, 0);
    check("conf_done_busy", r1_busy, 0);

    // Streaming both sources
    wlog.delete();
    ia = 0; ib = 0; run_a = 0; run_b = 0;
    for (int c = 0; c < 20 && (ia < 4 || ib < 4); c++) begin
      a_valid = (ia < 4); a_addr = AW'(1 + ia);  a_data = DW'(16'hA001 + ia);
      b_valid = (ib < 4); b_addr = AW'(10 + ib); b_data = DW'(16'hB001 + ib);
      r1_addr = a_addr; r2_addr = b_addr;
      hs_a = a_valid & a_ready;
      hs_b = b_valid & b_ready;
      run_a = (a_valid && !a_ready) ? run_a + 1 : 0;
      run_b = (b_valid && !b_ready) ? run_b + 1 : 0;
      check("a_stall_run", run_a >= 2, 0);
      check("b_stall_run", run_b >= 2, 0);
      tick();
      if (hs_a) ia++;
      if (hs_b) ib++;
    end
    a_valid = 0; b_valid = 0;
    check("stream_a_accepted", ia, 4);
    check("stream_b_accepted", ib, 4);
    tick(); tick(); tick();
    check("stream_writes", wlog.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("stream_order%0d", i), (i < wlog.size()) ? wlog[i] : 'x, exp_stream[i]);

    // Asynchronous reset mid-drain
    a_valid = 1; a_addr = 7; a_data = 16'h7777;
    b_valid = 1; b_addr = 9; b_data = 16'h9999;
    r1_addr = 7; r2_addr = 9;
    tick();
    a_valid = 0; b_valid = 0;
    check("pre_rst_we", rf_we, 1);
    #1 n_rst = 1'b0;
    #1;
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_ready", {a_ready, b_ready}, 2'b11);
    check("mid_rst_busy", {r1_busy, r2_busy}, 0);
    wc = write_count;
    tick(); tick();
    n_rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_no_write", write_count, wc);
    check("post_rst_we", rf_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
